// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: command-byte fields, FSM
// encodings and the fill byte sent when no read data is available.
package spi_pkg;

  localparam int WE_BIT  = 7;
  localparam int ADR_MSB = 6;
  localparam int ADR_LSB = 0;

  localparam logic [7:0] TURNAROUND = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } xfer_state_t;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_WAIT = 1'b1
  } bus_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser plus one edge-detect flop per pin. Reports the
// synchronised level and single-cycle rise/fall strobes for each pin.
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter int           N       = 3,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic [N-1:0] pins,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] sync_p0;
  logic [N-1:0] sync_p1;
  logic [N-1:0] edge_p2;

  // Synchroniser chain and edge-history flop; reset to the idle pin levels.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      edge_p2 <= RST_VAL;
    end else begin
      sync_p0 <= pins;
      sync_p1 <= sync_p0;
      edge_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~edge_p2;
  assign fall  = ~sync_p1 & edge_p2;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder bridging command/data bytes onto a Wishbone-like
// register bus. The first byte of a transaction is {we, adr[6:0]}; MISO
// returns STATUS_BYTE during it. Following bytes are writes (WR) or
// prefetched reads (RD, first data byte is a turnaround).
// Build option: define SPI_SLAVE_AUTOINC_EN to step the address after each
// write byte and each read issue; otherwise the address stays fixed.
module spi_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               ASB         = WIDTH - 2,
  parameter logic [WIDTH-1:0] STATUS_BYTE = 8'hA7
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             SCK,
  input  logic             SSEL,
  input  logic             MOSI,
  output logic             MISO,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ASB:0]     adr_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             err_o
);

`ifdef SPI_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic [2:0] pin_lvl, pin_rise, pin_fall;
  logic       sck_rise, sck_fall, ssel_rise, ssel_fall, ssel_lvl, mosi_lvl;
  logic       pin_edges_unused;

  // SSEL idles high, SCK and MOSI idle low.
  spi_pin_sync #(
    .N       (3),
    .RST_VAL (3'b100)
  ) u_pin_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .pins     ({SSEL, SCK, MOSI}),
    .level    (pin_lvl),
    .rise     (pin_rise),
    .fall     (pin_fall)
  );

  assign ssel_lvl  = pin_lvl[2];
  assign ssel_rise = pin_rise[2];
  assign ssel_fall = pin_fall[2];
  assign sck_rise  = pin_rise[1];
  assign sck_fall  = pin_fall[1];
  assign mosi_lvl  = pin_lvl[0];
  // MOSI edges and the SCK level carry no meaning for the protocol.
  assign pin_edges_unused = ^{pin_rise[0], pin_fall[0], pin_lvl[1]};

  xfer_state_t      st_q, st_d;
  bus_state_t       bus_q, bus_d;
  logic [2:0]       bit_cnt_q;
  logic [WIDTH-1:0] rx_q, tx_q, pref_q;
  logic [WIDTH-1:0] rx_byte, tx_val;
  logic             miso_q, err_q, pref_vld_q;
  logic [ASB:0]     adr_q, req_adr;
  logic             byte_done, cmd_done, tx_load, pref_take, rd_starve;
  logic             req_fire, req_we, req_ok, rd_capture;
  logic             pend_vld_q, pend_we_q;
  logic [ASB:0]     pend_adr_q;
  logic [WIDTH-1:0] pend_dat_q;
  logic             issue, issue_we, pend_set;
  logic [ASB:0]     issue_adr;
  logic [WIDTH-1:0] issue_dat;

  // Byte as it stands once the current MOSI bit is shifted in.
  assign rx_byte   = {rx_q[WIDTH-2:0], mosi_lvl};
  assign byte_done = sck_rise && (st_q != IDLE) && !ssel_rise && (bit_cnt_q == 3'd7);

  // Transaction next-state and per-byte actions.
  always_comb begin
    st_d      = st_q;
    tx_load   = 1'b0;
    tx_val    = TURNAROUND;
    req_fire  = 1'b0;
    req_we    = 1'b0;
    req_adr   = adr_q;
    pref_take = 1'b0;
    rd_starve = 1'b0;
    cmd_done  = 1'b0;
    if (ssel_rise) begin
      st_d = IDLE;
    end else begin
      case (st_q)
        IDLE: if (ssel_fall) st_d = CMD;
        CMD: if (byte_done) begin
          tx_load  = 1'b1;
          cmd_done = 1'b1;
          if (rx_byte[WE_BIT]) begin
            st_d = WR;
          end else begin
            st_d     = RD;
            req_fire = 1'b1;
            req_adr  = rx_byte[ADR_MSB:ADR_LSB];
          end
        end
        WR: if (byte_done) begin
          tx_load  = 1'b1;
          req_fire = 1'b1;
          req_we   = 1'b1;
        end
        RD: if (byte_done) begin
          tx_load = 1'b1;
          if (pref_vld_q) begin
            tx_val    = pref_q;
            pref_take = 1'b1;
            req_fire  = 1'b1;
          end else begin
            rd_starve = 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // Transaction state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) st_q <= IDLE;
    else           st_q <= st_d;
  end

  // Bit counter, MISO bit, sticky error, address and prefetch-valid flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bit_cnt_q  <= 3'd0;
      miso_q     <= 1'b0;
      err_q      <= 1'b0;
      adr_q      <= '0;
      pref_vld_q <= 1'b0;
    end else begin
      if (ssel_fall) begin
        bit_cnt_q <= 3'd0;
        miso_q    <= STATUS_BYTE[WIDTH-1];
      end else if (ssel_rise) begin
        bit_cnt_q <= 3'd0;
        miso_q    <= 1'b0;
      end else if (st_q != IDLE) begin
        if (sck_rise)      bit_cnt_q <= bit_cnt_q + 3'd1;
        else if (sck_fall) miso_q    <= tx_q[WIDTH-1];
      end

      if (ssel_fall)                         err_q <= 1'b0;
      else if (rd_starve || (req_fire && !req_ok)) err_q <= 1'b1;

      if (req_fire && AUTOINC) adr_q <= req_adr + 1'b1;
      else if (cmd_done)       adr_q <= rx_byte[ADR_MSB:ADR_LSB];

      if (ssel_fall || cmd_done || pref_take) pref_vld_q <= 1'b0;
      if (rd_capture)                         pref_vld_q <= 1'b1;
    end
  end

  // Receive/transmit shifters and prefetch data (no reset needed).
  always_ff @(posedge clk_i) begin
    if (ssel_fall) begin
      tx_q <= {STATUS_BYTE[WIDTH-2:0], 1'b0};
    end else if ((st_q != IDLE) && !ssel_rise) begin
      if (sck_rise) begin
        rx_q <= rx_byte;
        if (tx_load) tx_q <= tx_val;
      end else if (sck_fall) begin
        tx_q <= {tx_q[WIDTH-2:0], 1'b0};
      end
    end
    if (rd_capture) pref_q <= dat_i;
  end

  // A new request is accepted if the bus is free, or frees up this cycle.
  assign req_ok     = req_fire && (((bus_q == B_IDLE) && !pend_vld_q) ||
                                   ((bus_q == B_WAIT) && ack_i));
  assign rd_capture = (bus_q == B_WAIT) && ack_i && !we_o;

  // Bus next-state; a request accepted on an ack cycle is parked one cycle.
  always_comb begin
    bus_d     = bus_q;
    issue     = 1'b0;
    issue_we  = req_we;
    issue_adr = req_adr;
    issue_dat = rx_byte;
    pend_set  = 1'b0;
    case (bus_q)
      B_IDLE: begin
        if (pend_vld_q && !ssel_lvl) begin
          issue     = 1'b1;
          issue_we  = pend_we_q;
          issue_adr = pend_adr_q;
          issue_dat = pend_dat_q;
          bus_d     = B_WAIT;
        end else if (req_ok) begin
          issue = 1'b1;
          bus_d = B_WAIT;
        end
      end
      B_WAIT: if (ack_i) begin
        bus_d    = B_IDLE;
        pend_set = req_ok;
      end
      default: bus_d = B_IDLE;
    endcase
  end

  // Bus state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) bus_q <= B_IDLE;
    else           bus_q <= bus_d;
  end

  // Registered bus outputs and the one-entry parked request.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= '0;
      dat_o      <= '0;
      pend_vld_q <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_adr_q <= '0;
      pend_dat_q <= '0;
    end else begin
      if (issue) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= issue_we;
        adr_o <= issue_adr;
        dat_o <= issue_dat;
      end else if ((bus_q == B_WAIT) && ack_i) begin
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
        we_o  <= 1'b0;
      end

      if (pend_set) begin
        pend_vld_q <= 1'b1;
        pend_we_q  <= req_we;
        pend_adr_q <= req_adr;
        pend_dat_q <= rx_byte;
      end else if (bus_q == B_IDLE) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  assign MISO   = miso_q & ~ssel_lvl;
  assign busy_o = ~ssel_lvl;
  assign err_o  = err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as SPI master (mode 0, SCK period
// 16 clk) and as a register-bus slave with programmable ack delay.
module tb_spi_slave;

`ifdef SPI_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_ni, SCK, SSEL, MOSI;
  logic       MISO, cyc_o, stb_o, we_o, busy_o, err_o;
  logic [6:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i = 8'h00;
  logic       ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:127];
  int         ack_dly   = 2;
  bit         ack_block = 1'b0;
  int         wait_cnt  = 0;
  int         n_req     = 0;
  int         n_wr      = 0;
  logic       cyc_prev  = 1'b0;
  logic [6:0] wr_adr [0:15];
  logic [7:0] wr_dat [0:15];

  always #5 clk = ~clk;

  spi_slave dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .SCK      (SCK),
    .SSEL     (SSEL),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .cyc_o    (cyc_o),
    .stb_o    (stb_o),
    .we_o     (we_o),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .dat_i    (dat_i),
    .ack_i    (ack_i),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  // Bus slave: single-cycle ack after ack_dly cycles, logs writes.
  always @(negedge clk) begin
    if (!cyc_o) wait_cnt = 0;
    if (cyc_o && !cyc_prev) n_req = n_req + 1;
    cyc_prev = cyc_o;
    if (ack_i) begin
      ack_i = 1'b0;
    end else if (cyc_o && stb_o) begin
      wait_cnt = wait_cnt + 1;
      if (!ack_block && (wait_cnt >= ack_dly)) begin
        ack_i    = 1'b1;
        wait_cnt = 0;
        if (we_o) begin
          if (n_wr < 16) begin
            wr_adr[n_wr] = adr_o;
            wr_dat[n_wr] = dat_o;
          end
          n_wr = n_wr + 1;
        end else begin
          dat_i = mem[adr_o];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = b[i];
      clks(8);
      r[i] = MISO;
      SCK  = 1'b1;
      clks(8);
      SCK  = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    spi_bits(b, 8, r);
  endtask

  task automatic sel_low();
    SSEL = 1'b0;
    clks(8);
  endtask

  task automatic sel_high();
    clks(8);
    SSEL = 1'b1;
    clks(8);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_miso"}, 32'(MISO),   32'h0);
    check({pfx, "_cyc"},  32'(cyc_o),  32'h0);
    check({pfx, "_stb"},  32'(stb_o),  32'h0);
    check({pfx, "_we"},   32'(we_o),   32'h0);
    check({pfx, "_adr"},  32'(adr_o),  32'h0);
    check({pfx, "_dat"},  32'(dat_o),  32'h0);
    check({pfx, "_busy"}, 32'(busy_o), 32'h0);
    check({pfx, "_err"},  32'(err_o),  32'h0);
  endtask

  initial begin
    logic [7:0] rb;
    int base;

    for (int a = 0; a < 128; a++) mem[a] = 8'h00;
    mem[2] = 8'h5C;
    mem[3] = 8'hAA;
    mem[4] = 8'hBB;

    reset_ni = 1'b0;
    SSEL     = 1'b1;
    SCK      = 1'b0;
    MOSI     = 1'b0;
    clks(3);
    check_reset_vals("rst");
    reset_ni = 1'b1;
    clks(4);

    // Status byte on an otherwise empty command
    sel_low();
    check("idle_busy", 32'(busy_o), 32'h1);
    spi_byte(8'h00, rb);
    check("idle_status", 32'(rb), 32'hA7);
    check("idle_no_write", n_wr, 0);
    sel_high();
    check("idle_miso_hi", 32'(MISO), 32'h0);
    check("idle_busy_hi", 32'(busy_o), 32'h0);

    // Burst write, ack after 2 clk
    base = n_wr;
    sel_low();
    spi_byte(8'h85, rb);
    check("wr_status", 32'(rb), 32'hA7);
    spi_byte(8'h11, rb);
    spi_byte(8'h22, rb);
    clks(16);
    sel_high();
    check("wr_count", n_wr - base, 2);
    check("wr0_adr", 32'(wr_adr[base]), 32'h5);
    check("wr0_dat", 32'(wr_dat[base]), 32'h11);
    check("wr1_adr", 32'(wr_adr[base+1]), AUTOINC ? 32'h6 : 32'h5);
    check("wr1_dat", 32'(wr_dat[base+1]), 32'h22);
    check("wr_err", 32'(err_o), 32'h0);

    // Burst read from register 3
    sel_low();
    spi_byte(8'h03, rb);
    check("rd_status", 32'(rb), 32'hA7);
    spi_byte(8'h00, rb);
    check("rd_turn", 32'(rb), 32'h00);
    spi_byte(8'h00, rb);
    check("rd_byte2", 32'(rb), 32'hAA);
    spi_byte(8'h00, rb);
    check("rd_byte3", 32'(rb), AUTOINC ? 32'hBB : 32'hAA);
    sel_high();
    check("rd_err", 32'(err_o), 32'h0);

    // Write overrun: first write stalled, second byte dropped
    base = n_wr;
    ack_block = 1'b1;
    sel_low();
    spi_byte(8'h81, rb);
    spi_byte(8'h33, rb);
    spi_byte(8'h44, rb);
    clks(4);
    check("ovr_err", 32'(err_o), 32'h1);
    check("ovr_stalled", n_wr - base, 0);
    ack_block = 1'b0;
    clks(16);
    check("ovr_count", n_wr - base, 1);
    check("ovr_dat", 32'(wr_dat[base]), 32'h33);
    check("ovr_adr", 32'(wr_adr[base]), 32'h1);
    sel_high();
    check("ovr_sticky", 32'(err_o), 32'h1);

    // Late read ack: fill byte, error, then recovery
    ack_block = 1'b1;
    sel_low();
    check("err_clear", 32'(err_o), 32'h0);
    spi_byte(8'h02, rb);
    spi_byte(8'h00, rb);
    check("late_turn", 32'(rb), 32'h00);
    check("late_err", 32'(err_o), 32'h1);
    ack_block = 1'b0;
    spi_byte(8'h00, rb);
    check("late_fill", 32'(rb), 32'h00);
    spi_byte(8'h00, rb);
    check("late_recover", 32'(rb), 32'h5C);
    sel_high();

    // Abort after 4 bits of a write data byte
    base = n_req;
    sel_low();
    spi_byte(8'h8A, rb);
    spi_bits(8'hF0, 4, rb);
    SSEL = 1'b1;
    clks(12);
    check("abort_no_cycle", n_req - base, 0);
    check("abort_miso", 32'(MISO), 32'h0);
    check("abort_busy", 32'(busy_o), 32'h0);
    sel_low();
    spi_byte(8'h00, rb);
    check("abort_recover", 32'(rb), 32'hA7);
    sel_high();

    // Asynchronous reset while a read cycle is open
    ack_block = 1'b1;
    sel_low();
    spi_byte(8'h01, rb);
    clks(6);
    check("mid_cyc", 32'(cyc_o), 32'h1);
    check("mid_adr", 32'(adr_o), 32'h1);
    check("mid_we", 32'(we_o), 32'h0);
    @(negedge clk);
    #2;
    reset_ni = 1'b0;
    #1;
    check_reset_vals("arst");
    clks(2);
    SSEL = 1'b1;
    clks(4);
    reset_ni  = 1'b1;
    ack_block = 1'b0;
    clks(8);
    check("post_rst_cyc", 32'(cyc_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder for the command/data protocol driven by the TART SPI bus master. It sits in the FPGA system-clock domain: it oversamples SCK/SSEL/MOSI, decodes the command byte {we, adr[6:0]}, and turns each following byte into a Wishbone-like register access. Read data is returned on MISO, and a status byte is returned during the command byte.

## Interface
- `WIDTH`, 8, byte width (fixed at 8)
- `ASB`, WIDTH-2, MSB index of register address
- `STATUS_BYTE`, 8'hA7, pattern shifted out on MISO during the command byte
- `clk_i` in 1: system clock; SCK, SSEL and MOSI are oversampled on this clock
- `reset_ni` in 1: reset, asynchronous, active-low
- `SCK` in 1: SPI clock (asynchronous)
- `SSEL` in 1: slave select, active-low (asynchronous)
- `MOSI` in 1: serial data in, MSB first
- `MISO` out 1: serial data out, MSB first
- `cyc_o` out 1: bus cycle active
- `stb_o` out 1: bus strobe
- `we_o` out 1: bus write enable
- `adr_o` out ASB+1: register address
- `dat_o` out WIDTH: write data
- `dat_i` in WIDTH: read data
- `ack_i` in 1: bus acknowledge
- `busy_o` out 1: SPI transaction in progress (synced SSEL low)
- `err_o` out 1: sticky overrun flag; cleared at the next SSEL assertion

## Operation
- Pin sampling: SCK, SSEL and MOSI each pass through a 2-FF synchroniser, followed by one edge-detect FF.
- SPI mode 0: MOSI is sampled on the detected SCK rise. MISO is updated on the detected SCK fall.
- Transaction FSM:
  - IDLE -> CMD on the SSEL fall. At that point, load `STATUS_BYTE` into the TX shifter and clear `err_o`.
  - CMD: 8 bits are shifted in. After the 8th rise, latch we = bit7 and adr = bits6:0, then go to WR (we=1) or RD (we=0).
  - In WR and RD, a bit counter wraps 7->0 on every byte.
  - Any state -> IDLE on the SSEL rise. A partial byte is discarded, and no bus cycle is issued for it.
- Write (WR):
  - Each complete byte issues one write: cyc_o=stb_o=we_o=1, adr_o=adr, dat_o=byte.
  - The write is held until `ack_i`.
  - If the previous write is still unacked when a new byte completes, drop the new byte and set `err_o`.
- Read (RD):
  - On entry, issue a read at adr. The data is captured on `ack_i` into the prefetch register.
  - Data byte 1 is a turnaround byte: MISO = 8'h00.
  - For data byte n≥2, MISO shifts out the prefetch register. At the start of each byte, issue the next read.
  - If the prefetch is not valid when a byte starts, send 8'h00 and set `err_o`.
- Address stepping depends on `SPI_SLAVE_AUTOINC_EN` (see Configuration).
- Bus FSM:
  - B_IDLE -> B_WAIT when a request is issued.
  - B_WAIT -> B_IDLE on `ack_i`.
  - cyc_o, stb_o and we_o stay constant in B_WAIT.
  - An in-flight cycle completes normally even after SSEL rises. Once SSEL is high, no new cycles are issued.
- Reset values:
  - MISO=0, cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, busy_o=0, err_o=0.
  - Both FSMs in idle.
- MISO = 0 whenever synced SSEL is high.

## Timing
- Pin-to-detected-edge latency: 3 clk_i cycles.
- MISO changes 1 clk_i after the detected SCK fall, i.e. ≤4 clk_i after the pin edge.
- Requirement: f_clk ≥ 10 × f_SCK. SSEL setup to the first SCK rise must be ≥ 6 clk_i.
- Write: the bus request is asserted 1 clk_i after the 8th detected rise of a byte.
- Read: the bus slave must ack within 8 SCK periods minus 6 clk_i.
- `ack_i` in the same cycle as a new request: the ack completes the old cycle, and the new request is issued in the following cycle.
- Address wraps 7'h7F -> 7'h00.

## Configuration
- `SPI_SLAVE_AUTOINC_EN` defined: adr increments by 1 after each write byte and after each read issue.
- Undefined: adr stays fixed for the whole transaction, for streaming a single FIFO-style register.

## Structure
- Shared package `spi_pkg` holds:
  - command-byte field positions (WE_BIT=7, ADR field 6:0);
  - transaction state encodings (IDLE, CMD, WR, RD);
  - bus state encodings (B_IDLE, B_WAIT);
  - the turnaround fill value 8'h00.
- One sub-module: `spi_pin_sync`, which contains the 2-FF synchroniser plus edge detector and outputs rise/fall/level for each pin.

## Test plan
- Idle/status: reset, then SSEL low with 8 SCKs of MOSI=8'h00. Expect MISO=8'hA7 and no bus cycle.
- Burst write: command 8'h85, data 8'h11, 8'h22, bus acks after 2 clk. Expect writes (adr 5, 8'h11) and (adr 6, 8'h22) with AUTOINC; with it undefined, both to adr 5. err_o=0.
- Burst read: command 8'h03, 3 data bytes, registers 3=8'hAA and 4=8'hBB. Expect MISO 8'hA7, 8'h00, 8'hAA, 8'hBB.
- Overruns:
  - Write overrun: ack held low for 2 byte times. Expect the second byte dropped and err_o=1.
  - Read late ack: expect 8'h00 sent and err_o=1.
  - The next SSEL fall clears err_o.
- Abort: SSEL rises after 4 bits of a write data byte. Expect no bus cycle for that byte, return to IDLE, and MISO=0.
- Reset mid-transfer: reset_ni low during RD with cyc_o=1. Expect all outputs at their reset values immediately (asynchronous reset).
